// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer, round-robin selection,
// registered broadcast snooped by every reservation station and the ROB.
module cdb_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int ROB_W   = 4,
   parameter  int DATA_W  = 32,
   localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ROB_W-1:0]   req_robNum,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       iscast_out,
   output logic [ROB_W-1:0]           robNum_out,
   output logic [DATA_W-1:0]          data_out,
   output logic [GID_W-1:0]           grant_id,
   output logic [NUM_REQ-1:0]         pending
);

   logic [NUM_REQ-1:0] full;
   logic [ROB_W-1:0]   slot_rob  [NUM_REQ];
   logic [DATA_W-1:0]  slot_data [NUM_REQ];
   logic [GID_W-1:0]   rr;

   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] accept;
   logic [GID_W-1:0]   win;
   logic               any_grant;

   function automatic logic [GID_W-1:0] wrap_idx(input logic [GID_W-1:0] base, input int off);
      int s;
      s = (int'(base) + off) % NUM_REQ;
      return GID_W'(s);
   endfunction

   // Search begins just past the last winner, so every full slot is reached
   // within NUM_REQ cycles.
   always_comb begin
      // NOTE: combinational logic uses blocking assignments and gives every
      // output a default first, so no latch is inferred on the no-grant path.
      grant     = '0;
      win       = '0;
      any_grant = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         if (!any_grant && full[wrap_idx(rr, off)]) begin
            any_grant                = 1'b1;
            grant[wrap_idx(rr, off)] = 1'b1;
            win                      = wrap_idx(rr, off);
         end
      end
   end

   assign req_ready = ~full | grant;
   assign accept    = req_valid & req_ready;
   assign pending   = full;

   // NOTE: payload storage has no reset; the full bit alone says whether a slot
   // holds anything, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            slot_rob[i]  <= req_robNum[i*ROB_W +: ROB_W];
            slot_data[i] <= req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full       <= '0;
         iscast_out <= 1'b0;
         robNum_out <= '0;
         data_out   <= '0;
         grant_id   <= '0;
         rr         <= GID_W'(NUM_REQ - 1);
      end else if (flush) begin
         full       <= '0;
         iscast_out <= 1'b0;
      end else begin
         iscast_out <= any_grant;
         if (any_grant) begin
            robNum_out <= slot_rob[win];
            data_out   <= slot_data[win];
            grant_id   <= win;
            rr         <= win;
         end
         // A slot drained and refilled on the same edge stays full.
         full <= accept | (full & ~grant);
      end
   end

endmodule
